// File: rtl/la_capture_sequencer.sv
// Logic-analyzer capture sequencer: owns the trace-RAM write pointer and
// sample count, gates the core clock-enable (run / single-step / halt) and
// shares the single trace-RAM address port with host readout.
//
// state | meaning
// IDLE  | after reset, waiting for the first init edge
// ARMED | capture armed or paused; pointer kept
// RUN   | continuous capture, one sample per cycle
// STEP  | single core cycle with one sample
// HALT  | stopped by the core or by a full trace RAM; only init leaves
module la_capture_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_init,
  input  logic              step_en,
  input  logic              run_mode,
  input  logic              stop_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              la_run,
  output logic              la_we,
  output logic              sts_ce,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic              full,
  output logic [ADDR_W:0]   wr_cnt,
  output logic [2:0]        state
);

  localparam logic [ADDR_W:0] DEPTH      = (ADDR_W + 1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_LAST = DEPTH - (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    STEP  = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            cur_state;
  state_t            nxt_state;
  logic              init_q;
  logic              step_q;
  logic              run_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic              init_rise;
  logic              step_rise;
  logic              last_write;

  assign init_rise  = in_init & ~init_q;
  assign step_rise  = step_en & ~step_q;
  assign state      = cur_state;
  assign la_run     = (cur_state == RUN) | (cur_state == STEP);
  assign full       = (wr_cnt == DEPTH);
  assign la_we      = la_run & stop_n & ~full;
  assign last_write = la_we & (wr_cnt == DEPTH_LAST);
  assign sts_ce     = run_q & ~la_run;
  assign rd_gnt     = rd_req & ~la_run;
  assign mem_addr   = la_run ? wr_ptr : (rd_gnt ? rd_addr : wr_ptr);

  // Edge-detect history, clock-enable history and readout data-valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q   <= 1'b0;
      step_q   <= 1'b0;
      run_q    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      init_q   <= in_init;
      step_q   <= step_en;
      run_q    <= la_run;
      rd_valid <= rd_gnt;
    end
  end

  // Write pointer wraps; sample count saturates at DEPTH; arm clears both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (init_rise) begin
      wr_ptr <= '0;
      wr_cnt <= '0;
    end else if (la_we) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (wr_cnt != DEPTH) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; init edge overrides every other transition.
  always_comb begin
    nxt_state = cur_state;
    if (init_rise) begin
      nxt_state = ARMED;
    end else begin
      unique case (cur_state)
        IDLE:  nxt_state = IDLE;
        ARMED: begin
          if (run_mode)       nxt_state = RUN;
          else if (step_rise) nxt_state = STEP;
        end
        RUN: begin
          if (!stop_n)        nxt_state = HALT;
          else if (last_write) nxt_state = HALT;
          else if (!run_mode) nxt_state = ARMED;
        end
        STEP: begin
          if (!stop_n || last_write || full) nxt_state = HALT;
          else                               nxt_state = ARMED;
        end
        HALT:    nxt_state = HALT;
        default: nxt_state = IDLE;
      endcase
    end
  end

endmodule

// File: doc/la_capture_sequencer.md
# la_capture_sequencer

Sequencer for the DLX logic-analyzer capture path. It owns the trace-RAM write address and sample count, and decides cycle by cycle whether the core runs (`la_run`), whether a trace sample is written (`la_we`), and when the status register is loaded (`sts_ce`). It supports continuous run, single-step and stop/halt, and arbitrates the single trace-RAM address port between capture and host readout. It sits between the host control register bits and the trace RAM / core clock-enable.

## Interface
- `ADDR_W`, default 5: trace-RAM address width; `DEPTH = 2**ADDR_W` samples.
- `clk`  in  1  single clock for all state.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_init`  in  1  host init level; its rising edge (re)arms the capture.
- `step_en`  in  1  host step level; its rising edge requests one step.
- `run_mode`  in  1  level; 1 = continuous run, 0 = pause.
- `stop_n`  in  1  active-low stop condition from the core.
- `rd_req`  in  1  host readout request; held high until `rd_gnt`.
- `rd_addr`  in  ADDR_W  host readout address.
- `mem_addr`  out  ADDR_W  trace-RAM address: the write pointer when capturing, `rd_addr` when granted.
- `la_run`  out  1  core clock-enable for this cycle.
- `la_we`  out  1  trace-RAM write enable.
- `sts_ce`  out  1  status-register load pulse.
- `rd_gnt`  out  1  readout granted this cycle.
- `rd_valid`  out  1  RAM read data valid (one cycle after `rd_gnt`).
- `full`  out  1  all DEPTH samples have been written.
- `wr_cnt`  out  ADDR_W+1  samples written since the last arm.
- `state`  out  3  IDLE=0, ARMED=1, RUN=2, STEP=3, HALT=4.

## Operation
- Edge detect: `init_rise = in_init & ~init_q`; `step_rise = step_en & ~step_q`. `init_q` and `step_q` are registered and reset to 0.
- `la_run = (state==RUN) | (state==STEP)`.
- `la_we = la_run & stop_n & ~full`.
- `sts_ce = run_q & ~la_run`, where `run_q` is `la_run` registered.
- On every `la_we`: `wr_ptr` and `wr_cnt` increment. `wr_ptr` wraps modulo DEPTH. `wr_cnt` saturates at DEPTH, and `full = (wr_cnt == DEPTH)`.
- `init_rise` in any state:
  - next state is ARMED;
  - `wr_ptr` and `wr_cnt` clear to 0;
  - it has priority over every other transition.
- IDLE: waits for `init_rise`.
- ARMED:
  - `run_mode=1` goes to RUN;
  - otherwise `step_rise` goes to STEP;
  - otherwise stay.
- RUN, checked in priority order:
  - `stop_n=0` goes to HALT;
  - a write this cycle that makes `wr_cnt` reach DEPTH goes to HALT;
  - `run_mode=0` goes to ARMED (pause, pointer kept);
  - otherwise stay.
- RUN ignores `step_rise`.
- STEP lasts exactly one cycle. Next state is HALT if `stop_n=0` or the memory became full, else ARMED.
- HALT: `la_run=0`; leaves only on `init_rise`.
- Arbitration: capture has absolute priority.
  - `rd_gnt = rd_req & ~la_run`.
  - `mem_addr = la_run ? wr_ptr : (rd_gnt ? rd_addr : wr_ptr)`.
  - `rd_valid` is `rd_gnt` registered.
  - A request made during RUN or STEP waits; it is granted in the first cycle with `la_run=0`.

## Timing
- Reset values: state=IDLE, `wr_ptr=0`, `wr_cnt=0`, `full=0`, `init_q=0`, `step_q=0`, `run_q=0`.
- Consequently, during reset: `la_run=0`, `la_we=0`, `sts_ce=0`, `rd_gnt=0`, `rd_valid=0`.
- Edge to run latency:
  - `init_rise` or `step_rise` sampled at edge N changes state at edge N;
  - `la_run=1` in cycle N+1.
- `run_mode` high in ARMED gives `la_run` in the following cycle.
- `sts_ce` is high for exactly one cycle: the first cycle with `la_run=0` after any cycle with `la_run=1`. This includes the cycle after each STEP.
- `stop_n` acts combinationally on `la_we`: the sample in the cycle where `stop_n=0` is not written. `la_run` drops the next cycle.
- On the final write (`wr_cnt` DEPTH-1 to DEPTH), RUN goes to HALT. `la_run` drops the next cycle, and no write occurs at DEPTH.
- Asynchronous reset mid-RUN: all outputs go low immediately. No `sts_ce` pulse follows.
- `init_rise` during RUN: one cycle in ARMED (`la_run=0`, `sts_ce=1`). If `run_mode` is still 1, RUN resumes from pointer 0.
- Simultaneous `init_rise` and `step_rise` in ARMED: `init_rise` wins and the step is dropped.

## Test plan
- Reset, then `in_init` 0→1, then `run_mode=1` with `ADDR_W=3` and `stop_n=1`:
  - required response: 8 consecutive `la_we` at `mem_addr` 0..7;
  - then HALT, `full=1`, `wr_cnt=8`;
  - one `sts_ce` pulse.
- Armed, `run_mode=0`, three `step_en` pulses spaced 4 cycles apart:
  - required response: three single-cycle `la_run`/`la_we` at addresses 0, 1, 2;
  - each is followed by one `sts_ce`;
  - `wr_cnt=3`, state ARMED.
- RUN, with `stop_n=0` asserted at the 5th cycle:
  - required response: writes only at 0..3;
  - HALT next cycle, `sts_ce` one cycle later;
  - later `step_en` pulses have no effect until `in_init` rises.
- `rd_req` with `rd_addr=6` raised during RUN:
  - required response: `rd_gnt` stays 0 until `la_run` falls;
  - then `rd_gnt=1` with `mem_addr=6`, and `rd_valid` the next cycle.
- Assert `reset` mid-RUN at `wr_cnt=4`:
  - required response: immediate `la_run=0`, `wr_cnt=0`, state IDLE, no `sts_ce`.
- In RUN, `run_mode` 1→0→1:
  - required response: pause to ARMED with the pointer kept;
  - one `sts_ce` pulse;
  - writes resume at the next address.
